imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the RV32I SoC. It accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory write port. It holds the CPU core in reset until a complete, checksum-verified image has been written. It sits between the host byte source (UART receiver or bench driver) and the IMEM/CPU reset inputs inside the SoC top.

## Interface
Parameters:
- ADDR_WIDTH, 10, IMEM word-address width; capacity is 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; one clock domain.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready at posedge clk.
- imem_we  output  1  IMEM write strobe, one-cycle pulse.
- imem_addr  output  ADDR_WIDTH  IMEM word address.
- imem_wdata  output  32  IMEM write data.
- cpu_rst_n  output  1  active-low reset to the CPU core; released only on successful load.
- load_done  output  1  sticky; image loaded and verified.
- load_err  output  1  last frame failed (length or checksum).
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current frame.

## Operation
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (N = 16-bit word count), then 4*N data bytes (LSB first per word), then CSUM.
- CSUM is the XOR of LEN_LO, LEN_HI and all data bytes. SYNC_BYTE is excluded.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- IDLE: bytes other than SYNC_BYTE are accepted and discarded. SYNC_BYTE goes to LEN0 and clears the checksum, words_loaded and load_err.
- LEN0 -> LEN1: capture the low byte.
- LEN1: capture the high byte.
  - N > 2^ADDR_WIDTH goes to ERROR.
  - N == 0 goes to CSUM.
  - Otherwise goes to DATA.
- DATA: a 2-bit byte counter shifts each byte into the word assembler at position [8k+7:8k].
  - On the 4th byte, a write is scheduled.
  - After word N-1 is written, go to CSUM.
- CSUM: match goes to DONE; mismatch goes to ERROR.
- DONE: in_ready=0, load_done=1, cpu_rst_n=1. The block stays here until rst.
- ERROR: load_err=1 and cpu_rst_n stays 0. in_ready=1 and non-sync bytes are discarded. SYNC_BYTE restarts the frame at LEN0. IMEM contents from the failed frame are not erased.
- in_ready is 1 in every state except DONE.
- Arithmetic:
  - Word index counts 0..N-1 and does not wrap.
  - imem_addr = words_loaded[ADDR_WIDTH-1:0] at write time.
  - N == 2^ADDR_WIDTH is legal and fills memory exactly.

## Timing
- Reset values (asynchronous, while rst=0):
  - State = IDLE.
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst_n=0, load_done=0, load_err=0, words_loaded=0.
- All outputs are registered, except in_ready, which is decoded from state.
- Write latency: imem_we=1 for exactly one cycle, in the cycle after the posedge that accepted the 4th byte of a word. imem_addr and imem_wdata are valid in that same cycle. words_loaded increments on the posedge ending the write cycle.
- Back-to-back bytes (in_valid held high) are accepted every cycle with no stall. A new word's byte 0 may be accepted while the previous word's imem_we is high.
- Ordering: the last word's write completes before the CSUM byte is accepted, because the CSUM byte arrives at least one cycle later. This takes no extra stall.
- cpu_rst_n rises, and load_done sets, on the posedge after the CSUM byte is accepted. load_err sets on that same edge, or on the edge after LEN_HI for an oversize N.
- in_valid gaps of any length are allowed in any state; the state holds.
- rst asserted mid-frame aborts immediately:
  - cpu_rst_n returns to 0 and all counters clear.
  - Partially assembled words are never written.

## Test plan
- Load N=3 words 0x00000013, 0x00500093, 0x001080B3 back-to-back, correct CSUM -> three imem_we pulses at addr 0,1,2 with those data; cpu_rst_n=1 and load_done=1 one cycle after CSUM; in_ready=0 afterward.
- Same frame with CSUM XOR 0x01 -> load_err=1, cpu_rst_n=0. Resend the frame correctly -> load_err clears on SYNC, load_done=1.
- Garbage bytes 0x00, 0xFF, 0x5A before SYNC_BYTE -> no writes and no state change. A subsequent N=1 frame loads at addr 0.
- N=0 frame (A5 00 00 00) -> no imem_we pulses, load_done=1. N = 2^ADDR_WIDTH+1 -> load_err=1 after LEN_HI, no writes.
- Random in_valid gaps (0-5 idle cycles) across an N=16 frame -> identical IMEM contents and address sequence 0..15, one pulse each.
- Assert rst after the 2nd byte of word 5 -> all outputs at reset values asynchronously, no write for word 5. A full reload afterward succeeds.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Holds the core in reset until a checksummed image has been written.
module imem_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [7:0]  r_csum;
  logic [1:0]  r_bcnt;
  logic [23:0] r_wbuf;
  logic        w_fire;
  logic        w_sync;
  logic        w_big;
  logic        w_last;
  logic        w_ok;
  logic [15:0] w_n;

  assign in_ready = (r_state != S_DONE);
  assign w_fire   = in_valid && in_ready;
  assign w_sync   = (in_data == SYNC_BYTE);
  assign w_n      = {in_data, r_len[7:0]};
  assign w_big    = 32'(w_n) > (32'd1 << ADDR_WIDTH);
  // At the 4th byte the previous word's write has already retired,
  // so words_loaded is the index of the word being completed.
  assign w_last   = 32'(words_loaded) == (32'(r_len) - 32'd1);
  assign w_ok     = (r_csum == in_data);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Frame parser: advances only on an accepted byte
  always_comb begin
    w_next = r_state;
    if (w_fire) begin
      unique case (r_state)
        S_IDLE, S_ERROR: if (w_sync) w_next = S_LEN0;
        S_LEN0: w_next = S_LEN1;
        S_LEN1: begin
          if (w_big)           w_next = S_ERROR;
          else if (w_n == '0)  w_next = S_CSUM;
          else                 w_next = S_DATA;
        end
        S_DATA: if (r_bcnt == 2'd3 && w_last) w_next = S_CSUM;
        S_CSUM: w_next = w_ok ? S_DONE : S_ERROR;
        default: w_next = r_state;
      endcase
    end
  end

  // Length/checksum capture, word assembly and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len        <= '0;
      r_csum       <= '0;
      r_bcnt       <= '0;
      r_wbuf       <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) words_loaded <= words_loaded + 1'b1;
      if (w_fire) begin
        unique case (r_state)
          S_IDLE, S_ERROR: begin
            if (w_sync) begin
              r_csum       <= '0;
              r_bcnt       <= '0;
              words_loaded <= '0;
              load_err     <= 1'b0;
            end
          end
          S_LEN0: begin
            r_len[7:0] <= in_data;
            r_csum     <= r_csum ^ in_data;
          end
          S_LEN1: begin
            r_len  <= w_n;
            r_csum <= r_csum ^ in_data;
            if (w_big) load_err <= 1'b1;
          end
          S_DATA: begin
            r_csum <= r_csum ^ in_data;
            r_bcnt <= r_bcnt + 2'd1;
            unique case (r_bcnt)
              2'd0: r_wbuf[7:0]   <= in_data;
              2'd1: r_wbuf[15:8]  <= in_data;
              2'd2: r_wbuf[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
                imem_wdata <= {in_data, r_wbuf};
              end
            endcase
          end
          S_CSUM: begin
            if (w_ok) begin
              load_done <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              load_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level scoreboard bench for imem_loader.
// Expected writes are predicted per word from the bytes sent.
module tb_imem_loader;
  localparam int         AW   = 10;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic          m_done = 1'b0;
  logic          m_err  = 1'b0;
  int            m_base = 0;
  int            m_wr_total = 0;
  int            q_addr[$];
  logic [31:0]   q_data[$];
  int            q_cyc[$];
  logic [31:0]   fw[1024];
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;
  logic [7:0]    last_csum = '0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic int rg(input int gmax);
    return int'($urandom_range(gmax, 0));
  endfunction

  task automatic chk_reset_vals();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    chk("rst_wl", 64'(words_loaded), 64'd0);
  endtask

  // called away from the clock edge; returns at #1 after a posedge
  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_reset_vals();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_base = m_wr_total;
    chk("no_pending_write", 64'(q_addr.size()), 64'd0);
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, byte 0x%0h", t, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] cerr,
                            input int gmax, input int abort_at);
    logic [7:0] cs;
    int nw;
    cs = 8'(n) ^ 8'(n >> 8);
    nw = (n > 1024) ? 0 : n;
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++) cs = cs ^ fw[i][8*k +: 8];
    last_csum = cs;
    send_byte(SYNC, rg(gmax));
    m_err  = 1'b0;
    m_base = m_wr_total;
    send_byte(8'(n), rg(gmax));
    send_byte(8'(n >> 8), rg(gmax));
    if (n > 1024) begin
      m_err = 1'b1;
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (abort_at >= 0 && i * 4 + k == abort_at) begin
          in_valid = 1'b0;
          return;
        end
        send_byte(fw[i][8*k +: 8], rg(gmax));
        if (k == 3) begin
          q_addr.push_back(i);
          q_data.push_back(fw[i]);
          q_cyc.push_back(cyc);
        end
      end
    end
    send_byte(cs ^ cerr, rg(gmax));
    if (cerr == 8'h00) m_done = 1'b1;
    else               m_err  = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) fw[i] = $urandom;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!m_done));
        chk("cpu_rst_n", 64'(cpu_rst_n), 64'(m_done));
        chk("load_done", 64'(load_done), 64'(m_done));
        chk("load_err", 64'(load_err), 64'(m_err));
        chk("words_loaded", 64'(words_loaded), 64'(m_wr_total - m_base));
        if (imem_we) begin
          m_wr_total++;
          last_addr = imem_addr;
          last_data = imem_wdata;
          if (q_addr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_we: got write addr %0d data 0x%0h, expected none",
                     imem_addr, imem_wdata);
          end else begin
            chk("we_addr", 64'(imem_addr), 64'(q_addr.pop_front()));
            chk("we_data", 64'(imem_wdata), 64'(q_data.pop_front()));
            chk("we_cycle", 64'(cyc), 64'(q_cyc.pop_front()));
          end
        end
      end
    join_none

    #3;
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // three-word image, back-to-back
    fw[0] = 32'h00000013;
    fw[1] = 32'h00500093;
    fw[2] = 32'h001080B3;
    send_frame(3, 8'h00, 0, -1);
    chk("t1_csum_model", 64'(last_csum), 64'hF0);
    chk("t1_done", 64'(load_done), 64'd1);
    chk("t1_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("t1_wl", 64'(words_loaded), 64'd3);
    chk("t1_last_addr", 64'(last_addr), 64'd2);
    chk("t1_last_data", 64'(last_data), 64'h001080B3);
    in_valid = 1'b1;
    in_data  = SYNC;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t1_ready_low", 64'(in_ready), 64'd0);
    chk("t1_still_done", 64'(load_done), 64'd1);
    do_reset();

    // bad checksum then a clean resend
    send_frame(3, 8'h01, 0, -1);
    chk("t2_err", 64'(load_err), 64'd1);
    chk("t2_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    send_frame(3, 8'h00, 0, -1);
    chk("t2_done", 64'(load_done), 64'd1);
    chk("t2_err_clr", 64'(load_err), 64'd0);
    do_reset();

    // garbage before sync
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    in_valid = 1'b0;
    chk("t3_wl", 64'(words_loaded), 64'd0);
    fw[0] = 32'hDEADBEEF;
    send_frame(1, 8'h00, 0, -1);
    chk("t3_addr", 64'(last_addr), 64'd0);
    chk("t3_data", 64'(last_data), 64'hDEADBEEF);
    do_reset();

    // empty image, oversize, then exact fill
    send_frame(0, 8'h00, 1, -1);
    chk("t4_done_n0", 64'(load_done), 64'd1);
    chk("t4_wl_n0", 64'(words_loaded), 64'd0);
    do_reset();
    send_frame(1025, 8'h00, 0, -1);
    chk("t4_oversize_err", 64'(load_err), 64'd1);
    fill_rand(1024);
    send_frame(1024, 8'h00, 0, -1);
    chk("t4_full_done", 64'(load_done), 64'd1);
    chk("t4_full_wl", 64'(words_loaded), 64'd1024);
    chk("t4_full_last", 64'(last_addr), 64'd1023);
    do_reset();

    // sixteen words with random gaps
    fill_rand(16);
    send_frame(16, 8'h00, 5, -1);
    chk("t5_wl", 64'(words_loaded), 64'd16);
    chk("t5_last", 64'(last_addr), 64'd15);
    do_reset();

    // reset after byte 1 of word 5, then full reload
    fill_rand(8);
    send_frame(8, 8'h00, 0, 22);
    #2;
    do_reset();
    send_frame(8, 8'h00, 2, -1);
    chk("t6_done", 64'(load_done), 64'd1);
    chk("t6_wl", 64'(words_loaded), 64'd8);
    do_reset();

    // random frames, some with corrupted checksum
    for (int r = 0; r < 8; r++) begin
      int n;
      logic [7:0] ce;
      n = int'($urandom_range(20, 1));
      fill_rand(n);
      for (int g = 0; g < rg(2); g++) send_byte(8'(($urandom_range(254, 0) + 8'hA6)), 0);
      in_valid = 1'b0;
      ce = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      send_frame(n, ce, 3, -1);
      chk("rnd_wl", 64'(words_loaded), 64'(n));
      if (ce == 8'h00) do_reset();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
